// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Brief    : RS232 receiver that samples each bit at mid-bit and delivers one
//            byte per frame. Parity bit and check exist only when
//            UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int                 c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_rx_meta;
  logic               r_rx_sync;
  logic               r_rx_prev;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_busy;

`ifdef UART_RX_PARITY_EN
  localparam logic c_ODD_BIT = (PARITY_ODD != 0);

  logic r_par_mis;
  logic r_parity_err;
  logic w_parity_exp;

  assign w_parity_exp = (^r_shift) ^ c_ODD_BIT;
  assign parity_err   = r_parity_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (PARITY_ODD != 0);
  assign parity_err   = 1'b0;
`endif

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

  // Synchronizer resets to the idle level so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Outputs are loaded on the stop-sample edge so they are visible during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          if (r_rx_prev && !r_rx_sync) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_baud_cnt == c_HALF_M1) begin
            r_baud_cnt <= '0;
            if (!r_rx_sync) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_baud_cnt == c_LAST) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_baud_cnt == c_LAST) begin
            r_baud_cnt <= '0;
            r_par_mis  <= r_rx_sync ^ w_parity_exp;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end
`endif

        S_STOP: begin
          if (r_baud_cnt == c_LAST) begin
            r_baud_cnt  <= '0;
            r_rx_data   <= r_shift;
            r_frame_err <= !r_rx_sync;
            r_rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_mis;
`endif
            r_state     <= S_DONE;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

        S_DONE: begin
          r_baud_cnt <= '0;
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end

        default: begin
          r_baud_cnt <= '0;
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: randomized frames against a timing/content model of the serial protocol.
`default_nettype none

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int ODD  = 0;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
  localparam bit HAS_PAR  = 1'b1;
`else
  localparam int STOP_IDX = 9;
  localparam bit HAS_PAR  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One entry per line event: busy window and, for real frames, the byte to deliver.
  typedef struct {
    int         busy_from;
    int         last;
    bit         deliver;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t pend[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_pe   = 1'b0;
  logic       exp_fe   = 1'b0;
  logic       exp_valid;
  logic       exp_busy;

  int         strobes     = 0;
  int         last_strobe = -1;
  logic [7:0] last_data   = 8'h00;
  logic       last_pe     = 1'b0;
  logic       last_fe     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the clock edge.
  always @(posedge clk) begin
    #1;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    if (rst) begin
      pend.delete();
      exp_data = 8'h00;
      exp_pe   = 1'b0;
      exp_fe   = 1'b0;
    end else begin
      foreach (pend[i])
        if (cyc >= pend[i].busy_from && cyc <= pend[i].last) exp_busy = 1'b1;
      if (pend.size() > 0 && pend[0].last == cyc) begin
        if (pend[0].deliver) begin
          exp_valid = 1'b1;
          exp_data  = pend[0].d;
          exp_pe    = pend[0].pe;
          exp_fe    = pend[0].fe;
        end
        void'(pend.pop_front());
      end
    end
    chk("rx_valid",   rx_valid,   exp_valid);
    chk("busy",       busy,       exp_busy);
    chk("rx_data",    rx_data,    exp_data);
    chk("parity_err", parity_err, exp_pe);
    chk("frame_err",  frame_err,  exp_fe);
    if (rx_valid === 1'b1) begin
      strobes++;
      last_strobe = cyc;
      last_data   = rx_data;
      last_pe     = parity_err;
      last_fe     = frame_err;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; the pin falls before the next rising edge (cycle p).
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            output int p);
    exp_t e;
    logic par;
    par = (^d) ^ (ODD != 0);
    if (bad_par) par = ~par;
    p           = cyc + 1;
    e.busy_from = p + 2;
    e.last      = p + 2 + HALF + STOP_IDX * CPB;
    e.deliver   = 1'b1;
    e.d         = d;
    e.pe        = HAS_PAR && bad_par;
    e.fe        = bad_stop;
    pend.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (HAS_PAR) drive_bit(par);
    drive_bit(!bad_stop);
  endtask

  task automatic send_glitch(input int g, output int p);
    exp_t e;
    p           = cyc + 1;
    e.busy_from = p + 2;
    e.last      = p + 1 + HALF;
    e.deliver   = 1'b0;
    e.d         = 8'h00;
    e.pe        = 1'b0;
    e.fe        = 1'b0;
    pend.push_back(e);
    rx = 1'b0;
    repeat (g) @(negedge clk);
    idle(HALF + CPB);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   p;
    int   s0;
    int   nfr;
    exp_t e;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_busy",    busy,    1'b0);
    rst = 1'b0;
    idle(CPB);

    // 0xA5 with correct parity
    send_frame(8'hA5, 1'b0, 1'b0, p);
    idle(4);
    chk("a5_strobes", strobes, 1);
    chk("a5_data",    last_data, 8'hA5);
    chk("a5_latency", last_strobe - p, HAS_PAR ? 170 : 154);
    chk("a5_pe",      last_pe, 1'b0);
    chk("a5_fe",      last_fe, 1'b0);

    // 0x3C with wrong then correct parity
    send_frame(8'h3C, 1'b1, 1'b0, p);
    idle(4);
    chk("3c_bad_data", last_data, 8'h3C);
`ifdef UART_RX_PARITY_EN
    chk("3c_bad_pe",   last_pe, 1'b1);
`else
    chk("3c_bad_pe",   last_pe, 1'b0);
`endif
    send_frame(8'h3C, 1'b0, 1'b0, p);
    idle(4);
    chk("3c_good_pe",  last_pe, 1'b0);

    // 0x55 with a low stop bit and the line held low afterwards
    s0 = strobes;
    send_frame(8'h55, 1'b0, 1'b1, p);
    rx = 1'b0;
    repeat (40 - CPB) @(negedge clk);
    chk("55_strobes", strobes, s0 + 1);
    chk("55_data",    last_data, 8'h55);
    chk("55_fe",      last_fe, 1'b1);
    idle(2 * CPB);
    chk("55_no_retrigger", strobes, s0 + 1);

    // short glitch, then a clean frame
    s0 = strobes;
    send_glitch(4, p);
    chk("glitch_no_strobe", strobes, s0);
    send_frame(8'h81, 1'b0, 1'b0, p);
    idle(4);
    chk("81_data", last_data, 8'h81);
    chk("81_fe",   last_fe, 1'b0);

    // back-to-back frames
    s0 = strobes;
    send_frame(8'h00, 1'b0, 1'b0, p);
    send_frame(8'hFF, 1'b0, 1'b0, p);
    idle(4);
    chk("b2b_strobes", strobes, s0 + 2);
    chk("b2b_data",    last_data, 8'hFF);

    // reset in the middle of the data bits
    s0          = strobes;
    p           = cyc + 1;
    e.busy_from = p + 2;
    e.last      = p + 100000;
    e.deliver   = 1'b0;
    e.d         = 8'h00;
    e.pe        = 1'b0;
    e.fe        = 1'b0;
    pend.push_back(e);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_busy", busy,    1'b0);
    chk("rst_mid_fe",   frame_err, 1'b0);
    rst = 1'b0;
    idle(2 * CPB);
    chk("rst_mid_no_strobe", strobes, s0);
    send_frame(8'h7E, 1'b0, 1'b0, p);
    idle(4);
    chk("7e_data", last_data, 8'h7E);

    // randomized traffic
    s0  = strobes;
    nfr = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_glitch($urandom_range(1, HALF - 3), p);
      end else begin
        logic [7:0] d;
        bit         bp;
        bit         bs;
        d  = 8'($urandom);
        bp = ($urandom_range(0, 3) == 0);
        bs = ($urandom_range(0, 5) == 0);
        send_frame(d, bp, bs, p);
        nfr++;
        if (bs) idle(CPB + $urandom_range(0, CPB));
        else    idle($urandom_range(0, 2 * CPB));
      end
    end
    idle(2 * CPB);
    chk("random_strobes", strobes, s0 + nfr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the processor's RS232 link, the receive-side counterpart of the UART transmit controller. Samples the asynchronous `rx` line at mid-bit, deserializes a frame (start, 8 data bits LSB-first, optional parity, 1 stop), checks parity and framing, and presents each byte with a one-cycle strobe to the memory-mapped UART peripheral. Control FSM, baud counter, bit counter, synchronizer and shift register are all contained in this block.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit, 50 MHz / 115200. Must be ≥ 4.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Only meaningful with `UART_RX_PARITY_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `rx_data`  out  8  last received byte; holds until the next frame completes.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` and the error flags are valid in this cycle.
- `parity_err`  out  1  parity mismatch on the last frame; updated with `rx_valid`.
- `frame_err`  out  1  stop bit sampled low on the last frame; updated with `rx_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. A third flop holds the previous synchronized value for edge detection.
- Let HALF = CLKS_PER_BIT/2, using integer division. The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state entry.
- **IDLE**
  - Leaves only on a synchronized 1→0 edge, going to START.
  - A line stuck low never re-triggers reception.
- **START**
  - At counter = HALF-1, sample the line.
  - Sample 0: go to DATA, counter cleared.
  - Sample 1: false start (glitch). Go to IDLE; no strobe, no flags updated.
- **DATA**
  - At counter = CLKS_PER_BIT-1, sample and shift right into the shift register: bit 0 first, MSB ends at bit 7.
  - The 3-bit bit counter increments on each sample.
  - After the 8th sample, go to PARITY (macro defined) or STOP.
- **PARITY**
  - At counter = CLKS_PER_BIT-1, sample the bit.
  - Expected bit: XOR of the 8 data bits, inverted when `PARITY_ODD`=1.
  - The mismatch result is latched internally; go to STOP.
- **STOP**
  - At counter = CLKS_PER_BIT-1, sample; 0 means frame error. Go to DONE.
- **DONE**, one cycle:
  - Load `rx_data` from the shift register.
  - Load `parity_err` and `frame_err`.
  - Pulse `rx_valid`.
  - Go to IDLE.
- The FSM returns to IDLE at mid stop bit. This allows a new start edge at the nominal end of the stop bit, so back-to-back frames are received.
- A byte with `frame_err`=1 is still delivered. Software decides whether to discard it.
- No handshake or backpressure: if software has not read `rx_data` before the next DONE, that byte is overwritten.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. FSM in IDLE; shift register, counters and synchronizer cleared (synchronizer to 1).
- Reset mid-frame aborts immediately. No strobe is generated for the partial frame.
- T0 is the first cycle in which IDLE sees the synchronized edge; this is 2–3 clocks after the pin falls. START is entered at T0+1.
- Sample k (k=0 start, 1..8 data, 9 parity, 9/10 stop) occurs at T0 + HALF + k·CLKS_PER_BIT.
- `rx_valid` is high at stop-sample cycle + 1:
  - T0 + HALF + 10·CLKS_PER_BIT + 1 with parity;
  - T0 + HALF + 9·CLKS_PER_BIT + 1 without parity.
- `busy` rises at T0+1 and falls the cycle after `rx_valid`.
- All outputs are registered; no combinational path from `rx`.

## Configuration
- `UART_RX_PARITY_EN` defined: 11-bit frame with a PARITY state; `parity_err` is computed as above.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state and parity logic are not compiled.
  - Frame is 10 bits; DATA goes directly to STOP.
  - `parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Test plan
All scenarios use CLKS_PER_BIT=16, with `UART_RX_PARITY_EN` defined unless stated otherwise.
- 0xA5, even parity bit 0, stop 1 -> one `rx_valid` pulse; `rx_data`=0xA5, `parity_err`=0, `frame_err`=0; strobe at T0+8+160+1.
- 0x3C sent with parity bit 1 (correct is 0) -> `rx_data`=0x3C, `parity_err`=1; then 0x3C with parity 0 -> `parity_err`=0.
- 0x55 with stop bit 0, line held low 40 cycles -> `rx_data`=0x55, `frame_err`=1; no further `rx_valid` until the line rises and a new edge arrives.
- 4-cycle low glitch (< HALF=8) -> no `rx_valid`; `busy` high only about 8 cycles; next valid frame 0x81 received correctly.
- Back-to-back 0x00 then 0xFF, no idle gap -> two strobes, `rx_data` 0x00 then 0xFF, no errors.
- `rst` pulsed mid-DATA -> all outputs return to reset values, no strobe; following frame 0x7E received correctly. Repeat without macro: 10-bit frames, `parity_err` always 0.
